// File: rtl/mt_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mt_stream_pkg
//  Description : Shared constants for the mt_fsm sample streamer: TX state
//                encoding, UART 8N1 frame constants and the default baud
//                divider for a 33.33 MHz clock at 115200 baud.
//  Revision    : 1.0 - initial release
// ============================================================================
package mt_stream_pkg;

    localparam int unsigned c_bits_per_byte        = 8;
    localparam int unsigned c_bytes_per_word       = 4;
    localparam int unsigned c_default_clks_per_bit = 289;

    // UART line levels
    localparam logic c_line_idle  = 1'b1;
    localparam logic c_line_start = 1'b0;
    localparam logic c_line_stop  = 1'b1;

    // TX state encoding
    localparam int unsigned c_tx_state_w = 3;
    localparam logic [c_tx_state_w-1:0] c_st_idle  = 3'd0;
    localparam logic [c_tx_state_w-1:0] c_st_load  = 3'd1;
    localparam logic [c_tx_state_w-1:0] c_st_start = 3'd2;
    localparam logic [c_tx_state_w-1:0] c_st_data  = 3'd3;
    localparam logic [c_tx_state_w-1:0] c_st_stop  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/mt_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mt_sync_fifo
//  Description : Single-clock FIFO with show-ahead read data. A push while
//                full is accepted when a pop happens in the same cycle.
//  Ports       : clk, rst       - clock, asynchronous active-high reset
//                i_push, i_din  - write request and data
//                i_pop          - read request (head advances)
//                o_dout         - current head word
//                o_full, o_empty- occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module mt_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;

    logic w_pop_ok;
    logic w_push_ok;

    assign o_full    = (r_count == (c_aw+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop && !o_empty;
    // A slot freed by a same-cycle pop is immediately reusable.
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push_ok && w_pop_ok) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mt_uart_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : mt_uart_streamer
//  Description : Captures 32-bit samples from mt_fsm into a FIFO and sends
//                each one over UART 8N1, little-endian byte order.
//  Ports       : clk, rst        - clock, asynchronous active-high reset
//                random_number   - sample word, qualified by valid_rn
//                valid_rn        - sample strobe (no backpressure)
//                start           - pulse that arms a capture run
//                tx              - UART line, idle high
//                busy, done      - run in progress / sticky run complete
//                overflow_count  - words dropped on a full FIFO (saturating)
//                sent_count      - words fully transmitted this run
//  Revision    : 1.0 - initial release
// ============================================================================
module mt_uart_streamer
    import mt_stream_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = c_default_clks_per_bit,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned SAMPLE_LIMIT = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] random_number,
    input  logic        valid_rn,
    input  logic        start,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic [15:0] overflow_count,
    output logic [31:0] sent_count
);

    localparam int unsigned c_baud_w = $clog2(CLKS_PER_BIT);

    logic [c_tx_state_w-1:0] r_state;
    logic [c_tx_state_w-1:0] w_state_nxt;
    logic [c_baud_w-1:0]     r_baud;
    logic [2:0]              r_bit;
    logic [1:0]              r_byte_idx;
    logic [31:0]             r_word;
    logic [7:0]              w_cur_byte;

    logic                    r_busy;
    logic                    r_done;
    logic [15:0]             r_overflow;
    logic [31:0]             r_sent;
    logic [31:0]             r_captured;

    logic [31:0]             w_fifo_dout;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;

    logic w_pop;
    logic w_limit_ok;
    logic w_capture;
    logic w_push;
    logic w_drop;
    logic w_bit_end;
    logic w_word_end;
    logic w_complete;
    logic w_arm;

    assign w_pop      = (r_state == c_st_load);
    assign w_limit_ok = (SAMPLE_LIMIT == 0) || (r_captured < SAMPLE_LIMIT);
    assign w_capture  = valid_rn && r_busy && w_limit_ok;
    assign w_push     = w_capture && (!w_fifo_full || w_pop);
    assign w_drop     = w_capture && w_fifo_full && !w_pop;
    assign w_bit_end  = (r_baud == c_baud_w'(CLKS_PER_BIT - 1));
    assign w_word_end = (r_state == c_st_stop) && w_bit_end && (r_byte_idx == 2'd3);
    assign w_complete = (SAMPLE_LIMIT != 0) && r_busy && (r_sent == SAMPLE_LIMIT)
                        && w_fifo_empty && (r_state == c_st_idle);
    assign w_arm      = start && !r_busy;
    // r_word shifts right after each byte, so the active byte is always [7:0].
    assign w_cur_byte = r_word[7:0];

    mt_sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (random_number),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // ---------------- TX FSM ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (!w_fifo_empty) w_state_nxt = c_st_load;
            c_st_load:  w_state_nxt = c_st_start;
            c_st_start: if (w_bit_end) w_state_nxt = c_st_data;
            c_st_data:  if (w_bit_end && (r_bit == 3'd7)) w_state_nxt = c_st_stop;
            c_st_stop:  if (w_bit_end) w_state_nxt = (r_byte_idx == 2'd3) ? c_st_idle : c_st_start;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_baud     <= '0;
            r_bit      <= '0;
            r_byte_idx <= '0;
            r_word     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_st_load) begin
                r_word     <= w_fifo_dout;
                r_byte_idx <= '0;
                r_baud     <= '0;
                r_bit      <= '0;
            end else if (r_state != c_st_idle) begin
                r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
                if (w_bit_end && (r_state == c_st_data)) begin
                    r_bit <= r_bit + 1'b1;   // wraps to 0 after bit 7
                end
                if (w_bit_end && (r_state == c_st_stop) && (r_byte_idx != 2'd3)) begin
                    r_byte_idx <= r_byte_idx + 1'b1;
                    r_word     <= {8'h00, r_word[31:8]};
                end
            end
        end
    end

    // Line level decoded straight from registers so reset forces idle at once.
    always_comb begin
        tx = c_line_idle;
        case (r_state)
            c_st_start: tx = c_line_start;
            c_st_data:  tx = w_cur_byte[r_bit];
            c_st_stop:  tx = c_line_stop;
            default:    tx = c_line_idle;
        endcase
    end

    // ---------------- Run control and counters ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= '0;
            r_sent     <= '0;
            r_captured <= '0;
        end else if (w_arm) begin
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_overflow <= '0;
            r_sent     <= '0;
            r_captured <= '0;
        end else begin
            if (w_complete) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
            if (w_push) begin
                r_captured <= r_captured + 1'b1;
            end
            if (w_drop && (r_overflow != 16'hFFFF)) begin
                r_overflow <= r_overflow + 1'b1;
            end
            if (w_word_end) begin
                r_sent <= r_sent + 1'b1;
            end
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign overflow_count = r_overflow;
    assign sent_count     = r_sent;

endmodule
`default_nettype wire

// File: doc/mt_uart_streamer.md
Name: mt_uart_streamer

Overview:
- Consumer end of the mt_fsm output stream: captures `random_number` words qualified by `valid_rn` and buffers them in a small FIFO.
- Serialises each word over a UART 8N1 line so a host can log samples, replacing file capture on hardware.
- Sits between mt_fsm and the board TX pin, in the same clock domain.

Parameters:
- CLKS_PER_BIT, 289, clock cycles per UART bit (33.33 MHz / 115200); minimum 2.
- FIFO_DEPTH, 16, word FIFO depth; power of two, minimum 2.
- SAMPLE_LIMIT, 1000000, words to transmit per run; 0 means unlimited.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- random_number  input  32  sample from mt_fsm.
- valid_rn  input  1  sample-valid strobe; no backpressure is available to the source.
- start  input  1  single-cycle pulse that arms a capture run.
- tx  output  1  UART serial out; idle high.
- busy  output  1  high from an accepted start until done.
- done  output  1  sticky; high once a run completes; cleared by the next accepted start.
- overflow_count  output  16  words dropped because the FIFO was full; saturates at 16'hFFFF.
- sent_count  output  32  words fully transmitted in the current run.

Behaviour:
- Reset (asynchronous, immediate):
  - tx=1, busy=0, done=0, overflow_count=0, sent_count=0.
  - FIFO emptied, TX FSM in IDLE.
  - A frame in progress is abandoned and the line returns high immediately.
- Arming:
  - start while busy=0: busy=1 on the next edge; done, overflow_count, sent_count and the internal captured counter are cleared.
  - start while busy=1 is ignored.
- Capture:
  - On a clk edge, a word is written when valid_rn=1, busy=1, the FIFO is not full, and (SAMPLE_LIMIT==0 or captured < SAMPLE_LIMIT).
  - If valid_rn=1 and busy=1 with captured < SAMPLE_LIMIT but the FIFO is full, the word is dropped and overflow_count increments (saturating).
  - Words arriving after the limit is reached are ignored and are not counted as overflow.
- Simultaneous FIFO write and TX pop in the same cycle are both honoured.
  - With the FIFO full, a same-cycle pop frees a slot, so the write succeeds and is not an overflow.
- TX FSM states: IDLE, LOAD, START, DATA, STOP.
  - IDLE -> LOAD when the FIFO is non-empty; the pop happens in LOAD, which latches the word and sets byte_idx=0.
  - LOAD -> START on the next cycle; tx=0 for CLKS_PER_BIT cycles.
  - START -> DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - DATA -> STOP: tx=1 for CLKS_PER_BIT cycles.
  - STOP with byte_idx<3: byte_idx++, go to START with no extra gap.
  - STOP with byte_idx==3: sent_count++, go to IDLE.
- Byte order: little-endian; byte 0 = random_number[7:0] is sent first.
- Timing:
  - Latency from the first word written into an empty FIFO to the start-bit falling edge is 2 cycles.
  - One word occupies exactly 40*CLKS_PER_BIT cycles on the line.
- Completion:
  - Condition: SAMPLE_LIMIT!=0, sent_count==SAMPLE_LIMIT, FIFO empty, and FSM in IDLE.
  - On completion, done=1 and busy=0 on the same edge.
  - With SAMPLE_LIMIT=0 the run never completes; only rst stops it.
- Counters:
  - The baud counter counts 0..CLKS_PER_BIT-1 and reloads at each bit boundary.
  - sent_count wraps at 2^32, which is only reachable in unlimited mode.

Decomposition:
- Shared package mt_stream_pkg holds:
  - TX state encoding.
  - UART frame constants: BITS_PER_BYTE=8, BYTES_PER_WORD=4, idle/start/stop line levels.
  - Default CLKS_PER_BIT.
- One sub-module, mt_sync_fifo: parameterised width/depth single-clock FIFO.
  - Outputs full/empty flags and supports a same-cycle push and pop.
- The streamer top holds the capture logic, counters, and TX FSM.

Test Plan:
- Basic frame: CLKS_PER_BIT=4, SAMPLE_LIMIT=1; start, then one valid_rn with 32'h12345678.
  - tx decodes bytes 78,56,34,12.
  - Frame length is 160 cycles; start bit begins 2 cycles after the write.
  - done=1, sent_count=1, busy=0.
- Overflow: FIFO_DEPTH=4, CLKS_PER_BIT=4; valid_rn held high for 10 consecutive cycles with an incrementing value.
  - The first word is popped, then 4 are buffered: 5 transmitted, overflow_count=5.
  - The transmitted words are the first 5 values, in order.
- Limit: SAMPLE_LIMIT=3 with a continuous stream.
  - Exactly 3 words are sent, overflow_count=0, done=1.
  - Later valid_rn pulses change nothing.
- Ignore when unarmed: valid_rn pulses before start, and start asserted mid-run.
  - No capture before start, no transmission, and counters are unchanged by the second start.
- Reset mid-frame: assert rst during DATA bit 3.
  - tx=1 immediately (asynchronous), all outputs return to reset values.
  - A subsequent start transmits a fresh word correctly.
- Back-to-back: two words queued.
  - Stop bit of byte 3 of word 1 is followed directly by the start bit of word 2, after only the IDLE/LOAD 2-cycle gap.
  - sent_count=2.
